// File: rtl/pes_fp32_pkg.sv
// Shared FP32 definitions for the multiplier post-stage.
//   - Field constants (bias, all-ones exponent, canonical quiet NaN).
//   - Override class codes carried down the sideband delay line.
//   - Bit positions of the {nan, inf, zero} result flags.
//   - Operand classification and the issue-time override decision.
package pes_fp32_pkg;

    localparam logic [7:0]  BIAS    = 8'h7F;
    localparam logic [7:0]  EXP_MAX = 8'hFF;
    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] INF_MAG = 32'h7F800000;

    // Biased exponent sum limits: ea+eb-BIAS >= 255 overflows,
    // ea+eb-BIAS <= -1 underflows (flushed to zero).
    localparam logic [8:0] OVF_ESUM = {1'b0, EXP_MAX} + {1'b0, BIAS};
    localparam logic [8:0] UNF_ESUM = {1'b0, BIAS} - 9'd1;

    typedef enum logic [1:0] {
        CODE_PASS = 2'd0,
        CODE_NAN  = 2'd1,
        CODE_INF  = 2'd2,
        CODE_ZERO = 2'd3
    } fp_code_e;

    localparam int FLAG_NAN  = 2;
    localparam int FLAG_INF  = 1;
    localparam int FLAG_ZERO = 0;

    typedef struct packed {
        logic is_nan;
        logic is_inf;
        logic is_zero;
    } fp_class_t;

    // One sideband entry travelling alongside the multiplier pipeline.
    typedef struct packed {
        logic     valid;
        fp_code_e code;
        logic     sign;
    } dl_entry_t;

    // Denormals are flushed, so any zero exponent counts as zero.
    function automatic fp_class_t fp_classify(input logic [31:0] x);
        fp_class_t c;
        c.is_zero = (x[30:23] == 8'h00);
        c.is_inf  = (x[30:23] == EXP_MAX) && (x[22:0] == 23'd0);
        c.is_nan  = (x[30:23] == EXP_MAX) && (x[22:0] != 23'd0);
        return c;
    endfunction

    function automatic fp_code_e fp_override(input logic [31:0] a, input logic [31:0] b);
        fp_class_t  ca;
        fp_class_t  cb;
        logic [8:0] esum;
        fp_code_e   code;
        ca   = fp_classify(a);
        cb   = fp_classify(b);
        esum = {1'b0, a[30:23]} + {1'b0, b[30:23]};
        if (ca.is_nan || cb.is_nan || (ca.is_inf && cb.is_zero) || (cb.is_inf && ca.is_zero))
            code = CODE_NAN;
        else if (ca.is_inf || cb.is_inf)
            code = CODE_INF;
        else if (ca.is_zero || cb.is_zero)
            code = CODE_ZERO;
        else if (esum >= OVF_ESUM)
            code = CODE_INF;
        else if (esum <= UNF_ESUM)
            code = CODE_ZERO;
        else
            code = CODE_PASS;
        return code;
    endfunction

endpackage

// File: rtl/pes_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// Ports:
//   clk, rst (async, active-low)
//   wr_en/wr_data : push (ignored when full)
//   rd_en         : pop the head (ignored when empty)
//   rd_data       : head entry, reads as zero while empty
//   full, empty   : occupancy status
module pes_sync_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_wr;
    logic             do_rd;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end

    // Forcing zero while empty keeps the output clean after reset.
    assign rd_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/pes_fmul_post_stage.sv
// Post-stage for the non-stallable LATENCY-stage FP32 multiplier.
// Issues operand pairs under credit control, carries each pair's override
// class and sign down a delay line matched to the multiplier, then writes
// the corrected result and flags into a FWFT FIFO.
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_ready/in_a/in_b     : operand handshake
//   mul_a/mul_b                     : operands to the multiplier
//   mul_f                           : multiplier result, aligned with the tap
//   out_valid/out_ready/out_data    : result handshake
//   out_flags                       : {nan, inf, zero}
//   count                           : credits in use (in flight + stored)
module pes_fmul_post_stage
    import pes_fp32_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_a,
    input  logic [31:0]                in_b,
    output logic [31:0]                mul_a,
    output logic [31:0]                mul_b,
    input  logic [31:0]                mul_f,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_data,
    output logic [2:0]                 out_flags,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int             CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    logic            fire;
    logic            pop;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   count_next;
    dl_entry_t       dl_reg [LATENCY];
    dl_entry_t       tap;
    logic            fifo_wr;
    logic [34:0]     fifo_wr_data;
    logic [34:0]     fifo_rd_data;
    logic            fifo_full;
    logic            fifo_empty;
    logic [2:0]      wr_flags;
    logic [31:0]     wr_value;
    logic            unused_sink;

    assign mul_a = in_a;
    assign mul_b = in_b;

    // A credit is reserved at issue so every in-flight result already owns
    // a FIFO slot; this is what lets the multiplier run without a stall.
    assign in_ready = (count_reg < DEPTH_C);
    assign fire     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;

    always_comb begin
        count_next = count_reg;
        case ({fire, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count_reg <= '0;
        else      count_reg <= count_next;
    end

    assign count = count_reg;

    // Sideband delay line: entry 0 is tagged on the fire edge, the tap at
    // LATENCY-1 lines up with the multiplier output for that pair.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) dl_reg[i] <= '0;
        end else begin
            dl_reg[0].valid <= fire;
            dl_reg[0].code  <= fp_override(in_a, in_b);
            dl_reg[0].sign  <= in_a[31] ^ in_b[31];
            for (int i = 1; i < LATENCY; i++) dl_reg[i] <= dl_reg[i-1];
        end
    end

    assign tap = dl_reg[LATENCY-1];

    always_comb begin
        wr_flags = '0;
        wr_value = {tap.sign, mul_f[30:0]};
        case (tap.code)
            CODE_NAN: begin
                wr_flags[FLAG_NAN] = 1'b1;
                wr_value           = QNAN;
            end
            CODE_INF: begin
                wr_flags[FLAG_INF] = 1'b1;
                wr_value           = {tap.sign, INF_MAG[30:0]};
            end
            CODE_ZERO: begin
                wr_flags[FLAG_ZERO] = 1'b1;
                wr_value            = {tap.sign, 31'd0};
            end
            default: begin
                wr_flags = '0;
                wr_value = {tap.sign, mul_f[30:0]};
            end
        endcase
    end

    assign fifo_wr      = tap.valid;
    assign fifo_wr_data = {wr_flags, wr_value};

    pes_sync_fifo #(
        .WIDTH (35),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_valid = ~fifo_empty;
    assign out_flags = fifo_rd_data[34:32];
    assign out_data  = fifo_rd_data[31:0];

    // The multiplier's own sign is replaced by the XOR of operand signs, and
    // the credit scheme guarantees the FIFO is never written while full.
    assign unused_sink = mul_f[31] ^ fifo_full;

endmodule

// File: tb/tb_pes_fmul_post_stage.sv
module tb_pes_fmul_post_stage;

    localparam int LATENCY = 4;
    localparam int DEPTH   = 4;
    localparam int CW      = $clog2(DEPTH + 1);
    localparam int NDIR    = 12;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_a;
    logic [31:0]   in_b;
    logic [31:0]   mul_a;
    logic [31:0]   mul_b;
    logic [31:0]   mul_f;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic [2:0]    out_flags;
    logic [CW-1:0] count;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            n_results = 0;
    logic [34:0]   sb [$];
    logic [34:0]   mon_exp;
    logic [31:0]   mpipe [LATENCY];

    logic [31:0]   dir_a   [NDIR];
    logic [31:0]   dir_b   [NDIR];
    logic [34:0]   dir_exp [NDIR];

    pes_fmul_post_stage #(
        .LATENCY (LATENCY),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_f     (mul_f),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truncating FP32 multiply for normal operands.
    function automatic logic [31:0] fmul_model(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        logic [22:0] m;
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 10'd1;
        end else begin
            m = p[45:23];
        end
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    // Behavioural multiplier: sampled on the operand edge, F visible after
    // LATENCY-1 further edges.
    always @(posedge clk) begin
        mpipe[0] <= fmul_model(mul_a, mul_b);
        for (int i = 1; i < LATENCY; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_f = mpipe[LATENCY-1];

    task automatic check_eq(input string tag, input logic [34:0] got, input logic [34:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds the pair until accepted; leaves in_valid high so calls chain
    // back-to-back.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [34:0] want);
        bit fired;
        fired    = 1'b0;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !fired; i++) begin
            fired = in_ready;
            step();
        end
        check_eq("issue_accepted", 35'(fired), 35'd1);
        if (fired) begin
            sb.push_back(want);
            $display("issue  a=%08h b=%08h expect data=%08h flags=%03b", a, b, want[31:0], want[34:32]);
        end
    endtask

    task automatic timed_issue(input logic [31:0] a, input logic [31:0] b, input logic [34:0] want);
        issue(a, b, want);
        in_valid = 1'b0;
        repeat (LATENCY - 1) step();
        check_eq("valid_before_latency", 35'(out_valid), 35'd0);
        step();
        check_eq("valid_at_latency", 35'(out_valid), 35'd1);
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while (sb.size() != 0 && i < 200) begin
            step();
            i++;
        end
        check_eq("drain_done", 35'(sb.size()), 35'd0);
        sb.delete();
    endtask

    function automatic logic [31:0] rand_normal();
        logic [31:0] r;
        logic [7:0]  e;
        r = $urandom;
        e = 8'($urandom_range(100, 154));
        return {r[31], e, r[22:0]};
    endfunction

    // Result monitor and FIFO-overrun guard.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            check_eq("no_write_when_full", 35'(dut.fifo_wr & dut.fifo_full), 35'd0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_result", 35'(out_valid), 35'd0);
                end else begin
                    mon_exp = sb.pop_front();
                    n_results++;
                    check_eq("out_data", 35'(out_data), 35'(mon_exp[31:0]));
                    check_eq("out_flags", 35'(out_flags), 35'(mon_exp[34:32]));
                    $display("result #%0d data=%08h flags=%03b", n_results, out_data, out_flags);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int          fires;

        dir_a[0]  = 32'hFF800000; dir_b[0]  = 32'h40000000; dir_exp[0]  = {3'b010, 32'hFF800000};
        dir_a[1]  = 32'h7F800000; dir_b[1]  = 32'h00000000; dir_exp[1]  = {3'b100, 32'h7FC00000};
        dir_a[2]  = 32'h7F000000; dir_b[2]  = 32'h7F000000; dir_exp[2]  = {3'b010, 32'h7F800000};
        dir_a[3]  = 32'h80800000; dir_b[3]  = 32'h00800000; dir_exp[3]  = {3'b001, 32'h80000000};
        dir_a[4]  = 32'h5F800000; dir_b[4]  = 32'h5F800000; dir_exp[4]  = {3'b010, 32'h7F800000};
        dir_a[5]  = 32'h5F800000; dir_b[5]  = 32'h5F000000; dir_exp[5]  = {3'b000, 32'h7F000000};
        dir_a[6]  = 32'h1F800000; dir_b[6]  = 32'h1F800000; dir_exp[6]  = {3'b001, 32'h00000000};
        dir_a[7]  = 32'h1F800000; dir_b[7]  = 32'h20000000; dir_exp[7]  = {3'b000, 32'h00000000};
        dir_a[8]  = 32'h00000001; dir_b[8]  = 32'h3F800000; dir_exp[8]  = {3'b001, 32'h00000000};
        dir_a[9]  = 32'h3F800000; dir_b[9]  = 32'hFFC12345; dir_exp[9]  = {3'b100, 32'h7FC00000};
        dir_a[10] = 32'hC0000000; dir_b[10] = 32'h40400000; dir_exp[10] = {3'b000, 32'hC0C00000};
        dir_a[11] = 32'h00000000; dir_b[11] = 32'hFF800000; dir_exp[11] = {3'b100, 32'h7FC00000};

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        step();
        step();
        check_eq("reset_out_valid", 35'(out_valid), 35'd0);
        check_eq("reset_out_data", 35'(out_data), 35'd0);
        check_eq("reset_out_flags", 35'(out_flags), 35'd0);
        check_eq("reset_count", 35'(count), 35'd0);
        check_eq("reset_in_ready", 35'(in_ready), 35'd1);
        rst = 1'b1;
        step();

        // NaN operand from idle, with exact latency.
        timed_issue(32'h7FC00000, 32'h3F800000, {3'b100, 32'h7FC00000});
        wait_drain();

        // Specials and exponent boundaries, back-to-back.
        for (int i = 0; i < NDIR; i++) issue(dir_a[i], dir_b[i], dir_exp[i]);
        in_valid = 1'b0;
        wait_drain();

        // Random normal pairs, back-to-back.
        for (int i = 0; i < 16; i++) begin
            a = rand_normal();
            b = rand_normal();
            issue(a, b, {3'b000, a[31] ^ b[31], fmul_model(a, b)[30:0]});
        end
        in_valid = 1'b0;
        wait_drain();
        check_eq("count_idle", 35'(count), 35'd0);

        // Backpressure: credits cap issue at DEPTH.
        out_ready = 1'b0;
        fires     = 0;
        for (int c = 0; c < 8; c++) begin
            a = rand_normal();
            b = rand_normal();
            in_a     = a;
            in_b     = b;
            in_valid = 1'b1;
            if (in_ready) begin
                fires++;
                sb.push_back({3'b000, a[31] ^ b[31], fmul_model(a, b)[30:0]});
            end
            step();
        end
        in_valid = 1'b0;
        check_eq("bp_fires", 35'(fires), 35'(DEPTH));
        check_eq("bp_in_ready", 35'(in_ready), 35'd0);
        check_eq("bp_count", 35'(count), 35'(DEPTH));
        out_ready = 1'b1;
        step();
        check_eq("bp_in_ready_after_pop", 35'(in_ready), 35'd1);
        check_eq("bp_count_after_pop", 35'(count), 35'(DEPTH - 1));
        wait_drain();

        // Reset mid-operation.
        out_ready = 1'b0;
        issue(32'h3F800000, 32'h40000000, {3'b000, 32'h40000000});
        issue(32'h40000000, 32'h40000000, {3'b000, 32'h40800000});
        issue(32'h40400000, 32'h40000000, {3'b000, 32'h40C00000});
        in_valid = 1'b0;
        step();
        step();
        check_eq("pre_reset_count", 35'(count), 35'd3);
        check_eq("pre_reset_valid", 35'(out_valid), 35'd1);
        rst = 1'b0;
        #1;
        sb.delete();
        check_eq("mid_reset_out_valid", 35'(out_valid), 35'd0);
        check_eq("mid_reset_count", 35'(count), 35'd0);
        step();
        rst       = 1'b1;
        out_ready = 1'b1;
        repeat (12) step();
        check_eq("post_reset_out_valid", 35'(out_valid), 35'd0);
        check_eq("post_reset_count", 35'(count), 35'd0);
        timed_issue(32'hC0000000, 32'h40400000, {3'b000, 32'hC0C00000});
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
